// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the video path.
// Holds mode encodings, default luma weights (Rec.709 scaled by 2^8)
// and the filter pipeline latency, which the video generator also uses
// to keep its own sync timing aligned with the filtered pixels.
package vga_pkg;

  localparam int PIPE_LAT = 3;

  localparam int DEF_CW = 6;
  localparam int DEF_KW = 8;
  localparam int DEF_KR = 54;
  localparam int DEF_KG = 183;
  localparam int DEF_KB = 19;

  localparam logic [2:0] MODE_COLOUR = 3'd0;
  localparam logic [2:0] MODE_GREEN  = 3'd1;
  localparam logic [2:0] MODE_AMBER  = 3'd2;
  localparam logic [2:0] MODE_WHITE  = 3'd3;
  localparam logic [2:0] MODE_TINT   = 3'd4;

  // Sideband that travels alongside each pixel through the pipe.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] mode;
  } side_t;

  // Reserved encodings fall back to plain colour.
  function automatic logic [2:0] legal_mode(input logic [2:0] m);
    return (m > MODE_TINT) ? MODE_COLOUR : m;
  endfunction

  // Sideband value of an empty pipe slot: blanked, syncs idle.
  function automatic side_t side_idle(input logic sync_act);
    side_t s;
    s.hs   = ~sync_act;
    s.vs   = ~sync_act;
    s.de   = 1'b0;
    s.mode = MODE_COLOUR;
    return s;
  endfunction

endpackage

// File: rtl/vga_luma.sv
// vga_luma: weighted luma for one pixel, two register stages.
// Stage 1 registers the three channel products, stage 2 registers the
// rounded, saturated Y so it lines up with stage 2 of the parent pipe.
module vga_luma
  import vga_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int KW = DEF_KW,
  parameter int KR = DEF_KR,
  parameter int KG = DEF_KG,
  parameter int KB = DEF_KB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] y
);

  localparam int PW = CW + KW;
  localparam int SW = CW + KW + 2;

  logic [PW-1:0] pr_q, pr_d;
  logic [PW-1:0] pg_q, pg_d;
  logic [PW-1:0] pb_q, pb_d;
  logic [CW-1:0] y_q, y_d;
  logic [SW-1:0] sum;
  logic [CW+1:0] y_full;

  // Products, then round-to-nearest on the fractional bits and clamp.
  always_comb begin
    pr_d   = PW'(KR) * PW'(r);
    pg_d   = PW'(KG) * PW'(g);
    pb_d   = PW'(KB) * PW'(b);
    sum    = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + SW'(1 << (KW - 1));
    y_full = (CW + 2)'(sum >> KW);
    y_d    = (y_full > (CW + 2)'({CW{1'b1}})) ? {CW{1'b1}} : y_full[CW-1:0];
  end

  // Product and luma registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
      y_q  <= '0;
    end else begin
      pr_q <= pr_d;
      pg_q <= pg_d;
      pb_q <= pb_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/vga_mono_filter.sv
// vga_mono_filter: 3-stage colour-to-monochrome filter for the VGA pins.
// The requested mode is latched only on a fresh vsync assertion and then
// travels with its pixel, so a mode switch starts on a frame boundary.
// Optional scanline darkening is enabled with `define VGA_SCANLINE_EN.
module vga_mono_filter
  import vga_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int KW       = DEF_KW,
  parameter int KR       = DEF_KR,
  parameter int KG       = DEF_KG,
  parameter int KB       = DEF_KB,
  parameter int SYNC_POL = 0
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] tint_r,
  input  logic [CW-1:0] tint_g,
  input  logic [CW-1:0] tint_b,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic [2:0]    mode_active
);

  localparam logic SYNC_ACT = (SYNC_POL != 0);
  localparam int   TW       = 2 * CW;

  logic [CW-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [CW-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [CW-1:0] r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;
  side_t         side1_q, side1_d, side2_q, side2_d;
  logic          hs3_q, hs3_d, vs3_q, vs3_d, de3_q, de3_d;
  logic [2:0]    mode_active_q, mode_active_d;
  logic          vs_prev_q, vs_prev_d;
  logic          hist_valid_q, hist_valid_d;
  logic          vs_edge;
  logic [CW-1:0] y2;

`ifdef VGA_SCANLINE_EN
  logic hs_prev_q, hs_prev_d;
  logic parity_q, parity_d;
  logic par1_q, par1_d, par2_q, par2_d;
  logic hs_edge;
`endif

  vga_luma #(
    .CW (CW),
    .KW (KW),
    .KR (KR),
    .KG (KG),
    .KB (KB)
  ) u_luma (
    .clk   (clk_vga),
    .rst_n (rst_n),
    .r     (r_in),
    .g     (g_in),
    .b     (b_in),
    .y     (y2)
  );

  // Stages 1-2: vsync edge detect, mode latch, and carrying pixel plus sideband.
  // hist_valid keeps a vsync held active through reset from counting as an edge.
  always_comb begin
    vs_edge       = hist_valid_q && (vs_prev_q != SYNC_ACT) && (vsync_in == SYNC_ACT);
    mode_active_d = vs_edge ? legal_mode(mode) : mode_active_q;
    vs_prev_d     = vsync_in;
    hist_valid_d  = 1'b1;
    r1_d          = r_in;
    g1_d          = g_in;
    b1_d          = b_in;
    side1_d.hs    = hsync_in;
    side1_d.vs    = vsync_in;
    side1_d.de    = de_in;
    side1_d.mode  = mode_active_d;
    r2_d          = r1_q;
    g2_d          = g1_q;
    b2_d          = b1_q;
    side2_d       = side1_q;
  end

`ifdef VGA_SCANLINE_EN
  // Line parity: flips per hsync assertion, restarts even at each frame.
  always_comb begin
    hs_edge   = hist_valid_q && (hs_prev_q != SYNC_ACT) && (hsync_in == SYNC_ACT);
    hs_prev_d = hsync_in;
    if (vs_edge) begin
      parity_d = 1'b0;
    end else if (hs_edge) begin
      parity_d = ~parity_q;
    end else begin
      parity_d = parity_q;
    end
    par1_d = parity_d;
    par2_d = par1_q;
  end
`endif

  // Stage 3: map luma to the pixel's own mode; tint inputs are used live.
  always_comb begin
    r3_d = r2_q;
    g3_d = g2_q;
    b3_d = b2_q;
    case (side2_q.mode)
      MODE_GREEN: begin
        r3_d = '0;
        g3_d = y2;
        b3_d = '0;
      end
      MODE_AMBER: begin
        r3_d = y2;
        g3_d = y2 >> 1;
        b3_d = '0;
      end
      MODE_WHITE: begin
        r3_d = y2;
        g3_d = y2;
        b3_d = y2;
      end
      MODE_TINT: begin
        r3_d = CW'((TW'(y2) * (TW'(tint_r) + TW'(1))) >> CW);
        g3_d = CW'((TW'(y2) * (TW'(tint_g) + TW'(1))) >> CW);
        b3_d = CW'((TW'(y2) * (TW'(tint_b) + TW'(1))) >> CW);
      end
      default: begin
        r3_d = r2_q;
        g3_d = g2_q;
        b3_d = b2_q;
      end
    endcase
    if (!side2_q.de) begin
      r3_d = '0;
      g3_d = '0;
      b3_d = '0;
    end
`ifdef VGA_SCANLINE_EN
    if (par2_q) begin
      r3_d = r3_d >> 1;
      g3_d = g3_d >> 1;
      b3_d = b3_d >> 1;
    end
`endif
    hs3_d = side2_q.hs;
    vs3_d = side2_q.vs;
    de3_d = side2_q.de;
  end

  // All pipeline state; reset empties the pipe with syncs idle.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r1_q          <= '0;
      g1_q          <= '0;
      b1_q          <= '0;
      r2_q          <= '0;
      g2_q          <= '0;
      b2_q          <= '0;
      r3_q          <= '0;
      g3_q          <= '0;
      b3_q          <= '0;
      side1_q       <= side_idle(SYNC_ACT);
      side2_q       <= side_idle(SYNC_ACT);
      hs3_q         <= ~SYNC_ACT;
      vs3_q         <= ~SYNC_ACT;
      de3_q         <= 1'b0;
      mode_active_q <= MODE_COLOUR;
      vs_prev_q     <= ~SYNC_ACT;
      hist_valid_q  <= 1'b0;
`ifdef VGA_SCANLINE_EN
      hs_prev_q     <= ~SYNC_ACT;
      parity_q      <= 1'b0;
      par1_q        <= 1'b0;
      par2_q        <= 1'b0;
`endif
    end else begin
      r1_q          <= r1_d;
      g1_q          <= g1_d;
      b1_q          <= b1_d;
      r2_q          <= r2_d;
      g2_q          <= g2_d;
      b2_q          <= b2_d;
      r3_q          <= r3_d;
      g3_q          <= g3_d;
      b3_q          <= b3_d;
      side1_q       <= side1_d;
      side2_q       <= side2_d;
      hs3_q         <= hs3_d;
      vs3_q         <= vs3_d;
      de3_q         <= de3_d;
      mode_active_q <= mode_active_d;
      vs_prev_q     <= vs_prev_d;
      hist_valid_q  <= hist_valid_d;
`ifdef VGA_SCANLINE_EN
      hs_prev_q     <= hs_prev_d;
      parity_q      <= parity_d;
      par1_q        <= par1_d;
      par2_q        <= par2_d;
`endif
    end
  end

  assign r_out       = r3_q;
  assign g_out       = g3_q;
  assign b_out       = b3_q;
  assign hsync_out   = hs3_q;
  assign vsync_out   = vs3_q;
  assign de_out      = de3_q;
  assign mode_active = mode_active_q;

endmodule
